// File: rtl/arithm_drv.sv
// ----------------------------------------------------------------------------
// arithm_drv: operand sequencer and result collector for the `arithm` pipeline.
//
// The host fills an internal buffer of DEPTH operand triples (A, B, C) through
// the wr_* port and then pulses start with a count. The block presents the
// triples to `arithm` one per cycle with ce high, holds ce high for LAT more
// cycles to drain the pipeline, and returns every O tagged with the buffer
// index it belongs to.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   wr_en      in   buffer write strobe (ignored while busy)
//   wr_addr    in   [AW]      buffer write index
//   wr_a/b/c   in   [WIDTH]   operands to store
//   start      in   single-cycle run request (ignored unless idle)
//   count      in   [AW+1]    triples to issue, clamped to DEPTH
//   busy       out  run in progress
//   done       out  one-cycle end-of-run pulse
//   ce         out  clock enable to `arithm`
//   A/B/C      out  [WIDTH]   operands to `arithm`
//   O          in   [WIDTH]   signed result from `arithm`
//   res_valid  out  res_data/res_idx valid
//   res_data   out  [WIDTH]   captured result (bit-exact copy of O)
//   res_idx    out  [AW]      buffer index of the result
//
// Optional build macro ARITHM_DRV_CHECK_EN adds:
//   wr_e       in   [WIDTH]   expected result stored alongside each triple
//   err        out  sticky mismatch flag
//   err_cnt    out  [AW+1]    saturating mismatch counter
// Both clear on rst and on an accepted start.
//
// All outputs are registered.
// ----------------------------------------------------------------------------
module arithm_drv #(
    parameter int unsigned WIDTH = 14,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned LAT   = 3,
    parameter int unsigned AW    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_a,
    input  logic [WIDTH-1:0] wr_b,
    input  logic [WIDTH-1:0] wr_c,
`ifdef ARITHM_DRV_CHECK_EN
    input  logic [WIDTH-1:0] wr_e,
    output logic             err,
    output logic [AW:0]      err_cnt,
`endif
    input  logic             start,
    input  logic [AW:0]      count,
    output logic             busy,
    output logic             done,
    output logic             ce,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] C,
    input  logic [WIDTH-1:0] O,
    output logic             res_valid,
    output logic [WIDTH-1:0] res_data,
    output logic [AW-1:0]    res_idx
);

    // Drain counter must hold 0..LAT-1.
    localparam int unsigned DW = $clog2(LAT + 1);
    localparam logic [DW-1:0] LAST_DRAIN = DW'(LAT - 1);
    localparam logic [AW:0]   DEPTH_W    = DEPTH[AW:0];
    localparam logic [AW:0]   ONE_W      = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] ONE_IDX    = {{(AW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StDrain,
        StDone
    } state_e;

    // ------------------------------------------------------------------
    // Operand buffer (not reset; contents survive rst)
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] buf_a_q [DEPTH];
    logic [WIDTH-1:0] buf_b_q [DEPTH];
    logic [WIDTH-1:0] buf_c_q [DEPTH];

    state_e state_q, state_d;

    // Writes are only accepted outside a run so the buffer is stable while issuing.
    logic wr_accept;
    assign wr_accept = wr_en && ((state_q == StIdle) || (state_q == StDone));

    always_ff @(posedge clk) begin
        if (wr_accept) begin
            buf_a_q[wr_addr] <= wr_a;
            buf_b_q[wr_addr] <= wr_b;
            buf_c_q[wr_addr] <= wr_c;
        end
    end

    // ------------------------------------------------------------------
    // Sequencer state
    // ------------------------------------------------------------------
    logic [AW-1:0]    idx_q, idx_d;      // entry currently on A/B/C
    logic [AW:0]      cnt_q, cnt_d;      // latched, clamped count
    logic [DW-1:0]    drain_q, drain_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             ce_q, ce_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] c_q, c_d;
    logic             start_ok;

    // Valid/index pipe: LAT-1 internal stages, res_valid_q is the last stage.
    logic [LAT-2:0]   v_q, v_d;
    logic [AW-1:0]    vi_q [LAT-1];
    logic [AW-1:0]    vi_d [LAT-1];
    logic             rv_q, rv_d;
    logic [WIDTH-1:0] rd_q, rd_d;
    logic [AW-1:0]    ridx_q, ridx_d;

    logic [AW:0]      cnt_clamped;
    logic [AW:0]      last_idx;
    logic [AW-1:0]    idx_nxt;

    assign cnt_clamped = (count > DEPTH_W) ? DEPTH_W : count;
    assign last_idx    = cnt_q - ONE_W;
    assign idx_nxt     = idx_q + ONE_IDX;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        drain_d  = drain_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        ce_d     = ce_q;
        a_d      = a_q;
        b_d      = b_q;
        c_d      = c_q;
        start_ok = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    start_ok = 1'b1;
                    cnt_d    = cnt_clamped;
                    if (cnt_clamped == '0) begin
                        // Empty run: straight to the done pulse, never busy.
                        state_d = StDone;
                        done_d  = 1'b1;
                    end else begin
                        state_d = StIssue;
                        busy_d  = 1'b1;
                        ce_d    = 1'b1;
                        idx_d   = '0;
                        a_d     = buf_a_q[0];
                        b_d     = buf_b_q[0];
                        c_d     = buf_c_q[0];
                    end
                end
            end
            StIssue: begin
                if ({1'b0, idx_q} == last_idx) begin
                    // Last entry stays on A/B/C through the drain.
                    state_d = StDrain;
                    drain_d = '0;
                end else begin
                    idx_d = idx_nxt;
                    a_d   = buf_a_q[idx_nxt];
                    b_d   = buf_b_q[idx_nxt];
                    c_d   = buf_c_q[idx_nxt];
                end
            end
            StDrain: begin
                if (drain_q == LAST_DRAIN) begin
                    state_d = StDone;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    ce_d    = 1'b0;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Result capture: the pipe only advances on ce so it stays aligned with
    // the stages inside `arithm`.
    // ------------------------------------------------------------------
    always_comb begin
        v_d    = v_q;
        vi_d   = vi_q;
        rv_d   = rv_q;
        rd_d   = rd_q;
        ridx_d = ridx_q;

        if (ce_q) begin
            v_d[0]  = (state_q == StIssue);
            vi_d[0] = idx_q;
            for (int k = 1; k < int'(LAT) - 1; k++) begin
                v_d[k]  = v_q[k-1];
                vi_d[k] = vi_q[k-1];
            end
            rv_d = v_q[LAT-2];
            if (v_q[LAT-2]) begin
                rd_d   = O;
                ridx_d = vi_q[LAT-2];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            cnt_q   <= '0;
            drain_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ce_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            v_q     <= '0;
            for (int k = 0; k < int'(LAT) - 1; k++) begin
                vi_q[k] <= '0;
            end
            rv_q    <= 1'b0;
            rd_q    <= '0;
            ridx_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            drain_q <= drain_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ce_q    <= ce_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            v_q     <= v_d;
            vi_q    <= vi_d;
            rv_q    <= rv_d;
            rd_q    <= rd_d;
            ridx_q  <= ridx_d;
        end
    end

`ifdef ARITHM_DRV_CHECK_EN
    // ------------------------------------------------------------------
    // Expected-result checker: compares each captured result with the
    // expected value stored for its index.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] buf_e_q [DEPTH];
    logic             err_q, err_d;
    logic [AW:0]      ecnt_q, ecnt_d;

    always_ff @(posedge clk) begin
        if (wr_accept) begin
            buf_e_q[wr_addr] <= wr_e;
        end
    end

    always_comb begin
        err_d  = err_q;
        ecnt_d = ecnt_q;
        if (start_ok) begin
            err_d  = 1'b0;
            ecnt_d = '0;
        end else if (rv_q && (rd_q != buf_e_q[ridx_q])) begin
            err_d = 1'b1;
            if (ecnt_q != '1) begin
                ecnt_d = ecnt_q + ONE_W;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q  <= 1'b0;
            ecnt_q <= '0;
        end else begin
            err_q  <= err_d;
            ecnt_q <= ecnt_d;
        end
    end

    assign err     = err_q;
    assign err_cnt = ecnt_q;
`endif

    assign busy      = busy_q;
    assign done      = done_q;
    assign ce        = ce_q;
    assign A         = a_q;
    assign B         = b_q;
    assign C         = c_q;
    assign res_valid = rv_q;
    assign res_data  = rd_q;
    assign res_idx   = ridx_q;

endmodule

// File: tb/tb_arithm_drv.sv
// ----------------------------------------------------------------------------
// Bench for arithm_drv. A small `arithm` stand-in returns A through ce-enabled
// registers; results are checked through a scoreboard queue, run timing through
// a table of vectors, plus hand-written reset-mid-run and checker sequences.
// ----------------------------------------------------------------------------
module tb_arithm_drv;

    localparam int WIDTH = 14;
    localparam int DEPTH = 8;
    localparam int LAT   = 3;
    localparam int AW    = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             wr_en = 1'b0;
    logic [AW-1:0]    wr_addr = '0;
    logic [WIDTH-1:0] wr_a = '0;
    logic [WIDTH-1:0] wr_b = '0;
    logic [WIDTH-1:0] wr_c = '0;
    logic             start = 1'b0;
    logic [AW:0]      count = '0;
    logic             busy, done, ce, res_valid;
    logic [WIDTH-1:0] A, B, C, O, res_data;
    logic [AW-1:0]    res_idx;
`ifdef ARITHM_DRV_CHECK_EN
    logic [WIDTH-1:0] wr_e = '0;
    logic             err;
    logic [AW:0]      err_cnt;
`endif

    always #5 clk = ~clk;

    arithm_drv #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .LAT  (LAT),
        .AW   (AW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_a     (wr_a),
        .wr_b     (wr_b),
        .wr_c     (wr_c),
`ifdef ARITHM_DRV_CHECK_EN
        .wr_e     (wr_e),
        .err      (err),
        .err_cnt  (err_cnt),
`endif
        .start    (start),
        .count    (count),
        .busy     (busy),
        .done     (done),
        .ce       (ce),
        .A        (A),
        .B        (B),
        .C        (C),
        .O        (O),
        .res_valid(res_valid),
        .res_data (res_data),
        .res_idx  (res_idx)
    );

    // `arithm` stand-in: the operand sample edge plus the driver's capture
    // register bracket the LAT stages, so LAT-1 registers sit in between.
    logic [WIDTH-1:0] mdl_pipe [LAT-1];
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < LAT - 1; k++) mdl_pipe[k] <= '0;
        end else if (ce) begin
            mdl_pipe[0] <= A;
            for (int k = 1; k < LAT - 1; k++) mdl_pipe[k] <= mdl_pipe[k-1];
        end
    end
    assign O = mdl_pipe[LAT-2];

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    // Scoreboard
    typedef struct {
        logic [WIDTH-1:0] data;
        logic [AW-1:0]    idx;
    } exp_t;
    exp_t sb[$];

    always @(negedge clk) begin
        if (res_valid) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_res_valid: got idx %0d data %0d, want none",
                         res_idx, res_data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("res_data", int'(res_data), int'(e.data));
                chk("res_idx", int'(res_idx), int'(e.idx));
            end
        end
    end

    // Shadow copy of the operand buffer
    logic [WIDTH-1:0] sh_a [DEPTH];
    logic [WIDTH-1:0] sh_b [DEPTH];
    logic [WIDTH-1:0] sh_c [DEPTH];

    task automatic write_entry(input int i, input int a, input int b, input int c,
                               input int e);
        @(posedge clk);
        #1;
        wr_en   = 1'b1;
        wr_addr = AW'(i);
        wr_a    = WIDTH'(a);
        wr_b    = WIDTH'(b);
        wr_c    = WIDTH'(c);
`ifdef ARITHM_DRV_CHECK_EN
        wr_e    = WIDTH'(e);
`endif
        @(posedge clk);
        #1;
        wr_en   = 1'b0;
        sh_a[i] = WIDTH'(a);
        sh_b[i] = WIDTH'(b);
        sh_c[i] = WIDTH'(c);
        if (e < 0) $display("note: negative expected value");
    endtask

    task automatic load_pattern(input int pat);
        int a;
        case (pat)
            1: write_entry(0, 500, 3461, 2777, 500);
            2: for (int i = 0; i < DEPTH; i++) write_entry(i, i * 100, i + 1, 7 * i, i * 100);
            3: for (int i = 0; i < DEPTH; i++) begin
                a = int'($urandom_range(0, 16383));
                write_entry(i, a, int'($urandom_range(0, 16383)),
                            int'($urandom_range(0, 16383)), a);
            end
            4: for (int i = 0; i < DEPTH; i++)
                write_entry(i, 16383 - i * 3, 8192 + i, 16383 - i, 16383 - i * 3);
            default: ;
        endcase
    endtask

    typedef struct {
        int cnt;
        int pat;
        bit extra_start;
        bit wr3;
        int exp_done;  // cycle offset from start of the done pulse
        int exp_ce;    // number of ce (and busy) cycles
        int exp_rv;    // number of results
    } vec_t;

    task automatic run_vec(input vec_t v);
        int done_cnt = 0, first_done = -1, ce_cnt = 0, busy_cnt = 0;
        int rv_cnt = 0, first_rv = -1, last_rv = -1, op_bad = 0, ei;
        load_pattern(v.pat);
        @(posedge clk);
        #1;
        start = 1'b1;
        count = (AW + 1)'(v.cnt);
        for (int i = 0; i < v.exp_rv; i++) sb.push_back('{data: sh_a[i], idx: AW'(i)});
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            if (done) begin
                done_cnt++;
                if (first_done < 0) first_done = k;
            end
            if (busy) busy_cnt++;
            if (res_valid) begin
                rv_cnt++;
                if (first_rv < 0) first_rv = k;
                last_rv = k;
            end
            if (ce) begin
                ce_cnt++;
                ei = (k <= v.exp_rv) ? k - 1 : v.exp_rv - 1;
                if (ei < 0 || A !== sh_a[ei] || B !== sh_b[ei] || C !== sh_c[ei]) op_bad++;
            end
            if (k == 2 && v.extra_start) begin
                start = 1'b1;
                count = 1;
            end
            if (k == 3) start = 1'b0;
            if (k == 2 && v.wr3) begin
                wr_en   = 1'b1;
                wr_addr = 3;
                wr_a    = 14'h3FFF;
                wr_b    = 14'h3FFF;
                wr_c    = 14'h3FFF;
`ifdef ARITHM_DRV_CHECK_EN
                wr_e    = 14'h3FFF;
`endif
            end
            if (k == 3) wr_en = 1'b0;
        end
        chk("done_pulses", done_cnt, 1);
        chk("done_cycle", first_done, v.exp_done);
        chk("ce_cycles", ce_cnt, v.exp_ce);
        chk("busy_cycles", busy_cnt, v.exp_ce);
        chk("res_valid_cycles", rv_cnt, v.exp_rv);
        if (v.exp_rv > 0) begin
            chk("first_res_cycle", first_rv, LAT + 1);
            chk("last_res_cycle", last_rv, v.exp_rv + LAT);
        end
        chk("operand_errors", op_bad, 0);
        chk("sb_leftover", sb.size(), 0);
        sb.delete();
    endtask

    vec_t vecs[8];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ce_c, done_c, rv_c, busy_c;
        vec_t cv;

        vecs[0] = '{cnt: 1,  pat: 1, extra_start: 0, wr3: 0, exp_done: 5,  exp_ce: 4,  exp_rv: 1};
        vecs[1] = '{cnt: 8,  pat: 2, extra_start: 0, wr3: 0, exp_done: 12, exp_ce: 11, exp_rv: 8};
        vecs[2] = '{cnt: 0,  pat: 0, extra_start: 0, wr3: 0, exp_done: 1,  exp_ce: 0,  exp_rv: 0};
        vecs[3] = '{cnt: 12, pat: 0, extra_start: 0, wr3: 0, exp_done: 12, exp_ce: 11, exp_rv: 8};
        vecs[4] = '{cnt: 8,  pat: 0, extra_start: 1, wr3: 0, exp_done: 12, exp_ce: 11, exp_rv: 8};
        vecs[5] = '{cnt: 8,  pat: 0, extra_start: 0, wr3: 1, exp_done: 12, exp_ce: 11, exp_rv: 8};
        vecs[6] = '{cnt: 5,  pat: 3, extra_start: 0, wr3: 0, exp_done: 9,  exp_ce: 8,  exp_rv: 5};
        vecs[7] = '{cnt: 3,  pat: 4, extra_start: 0, wr3: 0, exp_done: 7,  exp_ce: 6,  exp_rv: 3};

        for (int i = 0; i < DEPTH; i++) begin
            sh_a[i] = '0;
            sh_b[i] = '0;
            sh_c[i] = '0;
        end

        // Reset and idle
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_ce", int'(ce), 0);
        chk("rst_abc", int'(A) | int'(B) | int'(C), 0);
        chk("rst_res_valid", int'(res_valid), 0);
        chk("rst_res_data", int'(res_data), 0);
        chk("rst_res_idx", int'(res_idx), 0);

        for (int v = 0; v < 8; v++) run_vec(vecs[v]);

        // Reset in the middle of a full run
        load_pattern(2);
        @(posedge clk);
        #1;
        start = 1'b1;
        count = 8;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("ce_after_rst", int'(ce), 0);
        ce_c = 0;
        done_c = 0;
        rv_c = 0;
        busy_c = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            ce_c += int'(ce);
            done_c += int'(done);
            rv_c += int'(res_valid);
            busy_c += int'(busy);
        end
        chk("rst_run_ce", ce_c, 0);
        chk("rst_run_done", done_c, 0);
        chk("rst_run_res_valid", rv_c, 0);
        chk("rst_run_busy", busy_c, 0);

`ifdef ARITHM_DRV_CHECK_EN
        // Deliberately wrong expected value for index 2
        for (int i = 0; i < 4; i++)
            write_entry(i, i * 11 + 1, i, i, (i == 2) ? i * 11 + 2 : i * 11 + 1);
        cv = '{cnt: 4, pat: 0, extra_start: 0, wr3: 0, exp_done: 8, exp_ce: 7, exp_rv: 4};
        run_vec(cv);
        chk("err_set", int'(err), 1);
        chk("err_cnt", int'(err_cnt), 1);
        @(posedge clk);
        #1;
        start = 1'b1;
        count = 1;
        sb.push_back('{data: sh_a[0], idx: '0});
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("err_clear", int'(err), 0);
        chk("err_cnt_clear", int'(err_cnt), 0);
        repeat (10) @(negedge clk);
        chk("sb_leftover_chk", sb.size(), 0);
`else
        cv = vecs[0];
        if (cv.cnt < 0) $display("note: unused");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
